// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register pending-write scoreboard and a power-up clearing sweep.
// Optional same-cycle writeback forwarding is enabled by defining REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DEPTH-1:0]  ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r, next_state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              ready_r;
  logic [DEPTH-1:0]  busy_r, busy_next_s;
  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [ADDR_W-1:0] sweep_addr_s;
  logic              wr_en_s, iss_en_s;
  logic [DEPTH-1:0]  clr_mask_s, set_mask_s;

  assign sweep_addr_s = cnt_r[ADDR_W-1:0];
  assign ready        = ready_r;

  // Writeback and issue only act in RUN and are dropped in a cycle with reset asserted.
  assign wr_en_s  = rst_n && (state_r == RUN) && we && (wa != ADDR_ZERO);
  assign iss_en_s = rst_n && (state_r == RUN) && iss_valid && (iss_addr != ADDR_ZERO);

  // State, sweep counter and ready flag registers.
  always_ff @(posedge clk) begin
    state_r <= next_state_s;
    cnt_r   <= cnt_next_s;
    ready_r <= (next_state_s == RUN);
  end

  // Next-state logic: sweep every register once, then run.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    if (!rst_n) begin
      next_state_s = INIT;
      cnt_next_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        INIT: begin
          if (cnt_r == LAST_CNT) begin
            next_state_s = RUN;
            cnt_next_s   = {CNT_W{1'b0}};
          end else begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          next_state_s = RUN;
        end
        default: begin
          next_state_s = INIT;
          cnt_next_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Issue is applied after the writeback clear so a same-address issue keeps the bit set.
  always_comb begin
    clr_mask_s  = wr_en_s  ? (ONE_HOT0 << wa)       : {DEPTH{1'b0}};
    set_mask_s  = iss_en_s ? (ONE_HOT0 << iss_addr) : {DEPTH{1'b0}};
    busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Scoreboard busy bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Register storage: cleared one entry per cycle by the sweep, otherwise written back.
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == INIT)) begin
      regs_r[sweep_addr_s] <= {DATA_W{1'b0}};
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign ra_s = rd_addr[g*ADDR_W +: ADDR_W];
    assign rd_data[g*DATA_W +: DATA_W] = data_s;
    assign rd_busy[g] = busy_s;

    // Combinational read port; address 0 and the INIT state always read as zero / not busy.
    always_comb begin
      data_s = {DATA_W{1'b0}};
      busy_s = 1'b0;
      if ((state_r == RUN) && (ra_s != ADDR_ZERO)) begin
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_en_s && (ra_s == wa)) begin
          data_s = wd;
          busy_s = iss_en_s && (iss_addr == wa);
        end else begin
          data_s = regs_r[ra_s];
          busy_s = busy_r[ra_s];
        end
`else
        data_s = regs_r[ra_s];
        busy_s = busy_r[ra_s];
`endif
      end else begin
        data_s = {DATA_W{1'b0}};
        busy_s = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        ready;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  reg_file_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[31:0] === e.d0 && rd_data[63:32] === e.d1 &&
          rd_busy === e.busy && ready === e.rdy) begin
        passed++;
      end else begin
        $display("FAIL %s: got d0=%h d1=%h busy=%b ready=%b, expected d0=%h d1=%h busy=%b ready=%b",
                 e.name, rd_data[31:0], rd_data[63:32], rd_busy, ready,
                 e.d0, e.d1, e.busy, e.rdy);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic iv, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
    rst_n = r; we = w; wa = a; wd = d; iss_valid = iv; iss_addr = ia; rd_addr = {ra1, ra0};
  endtask

  task automatic expect_out(input string n, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] b, input logic r);
    exp_t e;
    e.name = n; e.d0 = d0; e.d1 = d1; e.busy = b; e.rdy = r;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    expect_out("reset_low", 32'h0, 32'h0, 2'b00, 1'b0);
    tick();

    // Sweep after release: writes and issues offered during INIT must be ignored.
    for (int k = 1; k <= 32; k++) begin
      drive(1'b1, 1'b1, 5'd5, 32'hAAAA_AAAA, 1'b1, 5'd3, 5'(k - 1), 5'd5);
      expect_out($sformatf("init_sweep_%0d", k), 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
    end

    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd3);
    expect_out("ready_cycle33", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();

    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd5);
    expect_out("write5_same_cycle", BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd0, 32'd7, 1'b0, 5'd0, 5'd5, 5'd0);
    expect_out("read5_write0", 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd3);
    expect_out("reg0_zero_issue3", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd3, 32'd9, 1'b0, 5'd0, 5'd3, 5'd0);
    expect_out("busy3_wb3", BYP ? 32'd9 : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    expect_out("retired3", 32'd9, 32'd9, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 5'd4, 5'd0);
    expect_out("collide4_same", BYP ? 32'h11 : 32'h0, 32'h0, BYP ? 2'b01 : 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    expect_out("collide4_after", 32'h11, 32'h11, 2'b11, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd6, 32'h33, 1'b1, 5'd0, 5'd0, 5'd4);
    expect_out("write6_issue0", 32'h0, 32'h11, 2'b10, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd6, 32'h22, 1'b1, 5'd7, 5'd6, 5'd0);
    expect_out("bypass6", BYP ? 32'h22 : 32'h33, 32'h0, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 5'd6, 5'd7);
    expect_out("read6_collide7", 32'h22, BYP ? 32'h55 : 32'h0, 2'b10, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd6);
    expect_out("reg7_busy", 32'h55, 32'h22, 2'b01, 1'b1);
    tick();

    // Reset pulse mid-RUN; the write and issue offered with it are discarded.
    drive(1'b0, 1'b1, 5'd8, 32'h99, 1'b1, 5'd9, 5'd7, 5'd4);
    expect_out("rst_pulse_cycle", 32'h55, 32'h11, 2'b11, 1'b1);
    tick();
    for (int k = 1; k <= 32; k++) begin
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd4);
      expect_out($sformatf("resweep_%0d", k), 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd4);
    expect_out("after_resweep_7_4", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd9);
    expect_out("discarded_8_9", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd3);
    expect_out("cleared_5_3", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    tick();

    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 rd_addr  input  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
REQ-007 rd_data  output  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
REQ-008 rd_busy  output  NUM_RD  port i operand has a pending, unretired write.
REQ-009 we  input  1  writeback enable.
REQ-010 wa  input  ADDR_W  writeback address.
REQ-011 wd  input  DATA_W  writeback data.
REQ-012 iss_valid  input  1  an instruction that will write iss_addr is issuing.
REQ-013 iss_addr  input  ADDR_W  destination register of the issuing instruction.
REQ-014 ready  output  1  initialisation done; file accepts issue and writeback.

Function
REQ-015 FSM states: INIT, RUN; any cycle with rst_n low forces INIT next cycle.
REQ-016 INIT: 8-bit-or-wider sweep counter cnt, starting at 0, clears reg[cnt] each cycle with rst_n high; after clearing DEPTH-1, the next state is RUN.
REQ-017 ready = 1 only in RUN; ready rises exactly DEPTH cycles after the first posedge with rst_n high.
REQ-018 In INIT: we and iss_valid are ignored; every rd_data is 0; every rd_busy is 0.
REQ-019 Register 0 reads as 0 always; writes and issues to address 0 are ignored; rd_busy for address 0 is always 0.
REQ-020 Reads are combinational: rd_data[i] = reg[rd_addr[i]], zero-latency, all ports independent; identical addresses on several ports are legal.
REQ-021 Write in RUN: we=1 and wa!=0 stores wd into reg[wa] at posedge clk.
REQ-022 Scoreboard: one busy bit per register; iss_valid=1 and iss_addr!=0 sets busy[iss_addr] at posedge clk.
REQ-023 we=1 clears busy[wa] at posedge clk; writeback to a non-busy register is legal and only updates data.
REQ-024 Same cycle, iss_addr==wa: data is written, busy stays set (issue wins, newer write pending).
REQ-025 Same cycle, iss_addr!=wa: both actions take effect independently.
REQ-026 rd_busy[i] = busy[rd_addr[i]] in RUN, modified per REQ-030.
REQ-027 Values are stored unchanged; no width conversion; wd bits above DATA_W do not exist.

Reset
REQ-028 rst_n low at posedge: next state INIT, cnt=0, all busy bits 0, ready=0; register contents cleared by the INIT sweep, not in one cycle.
REQ-029 rst_n low mid-operation (RUN or mid-INIT) restarts the sweep from cnt=0; the writeback or issue presented that cycle is discarded.

Configuration
REQ-030 Macro REG_FILE_SB_BYPASS_EN defined: in RUN, if we=1, wa!=0 and rd_addr[i]==wa, rd_data[i]=wd and rd_busy[i]=0 in the same cycle, unless iss_valid=1 and iss_addr==wa, which keeps rd_busy[i]=1.
REQ-031 Macro undefined: no bypass; reads return the stored value and the registered busy bit, the new value is visible the cycle after the write.

Verification
REQ-032 Reset: rst_n low 2 cycles then high, DEPTH=32 -> ready=0 for 32 cycles, ready=1 on cycle 33; all reads 0 throughout.
REQ-033 Write/read: we=1, wa=5, wd=0xDEADBEEF -> next cycle rd_addr port0=5, port1=5 both give 0xDEADBEEF; we=1, wa=0, wd=7 -> reg 0 still reads 0.
REQ-034 Scoreboard: iss_valid, iss_addr=3 -> next cycle rd_busy=1 for addr 3; we, wa=3, wd=9 -> next cycle rd_busy=0, data 9.
REQ-035 Collision: iss_addr=4 and we wa=4 wd=0x11 in same cycle -> next cycle data 0x11, rd_busy=1.
REQ-036 Bypass: with REG_FILE_SB_BYPASS_EN, we wa=6 wd=0x22 and rd_addr=6 same cycle -> rd_data=0x22 combinationally; without macro -> old value, 0x22 next cycle.
REQ-037 Reset mid-RUN: busy set on reg 7, reg 7=0x55, pulse rst_n low 1 cycle -> ready=0, busy clear, after sweep reg 7 reads 0.
